// File: rtl/bin_to_bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter: one bit per clock,
// with a sticky overflow flag and a leading-zero blank mask for the display.

module bin_to_bcd_dig (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_iter #(
    parameter int BIN_W  = 64,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [BIN_W-1:0]    sh_q, sh_step;
    logic [4*DIGITS-1:0] wrk_q, wrk_adj, wrk_step;
    logic                carry_q, carry_out, carry_step;
    logic [CNT_W-1:0]    cnt_q;
    logic [DIGITS-1:0]   blank_nxt;
    logic                last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin_to_bcd_dig u_dig (.d(wrk_q[4*g +: 4]), .q(wrk_adj[4*g +: 4]));
    end

    // The bit leaving the top digit means the value no longer fits DIGITS digits.
    assign {carry_out, wrk_step, sh_step} = {wrk_adj, sh_q, 1'b0};
    assign carry_step = carry_q | carry_out;
    assign last       = (cnt_q == CNT_W'(1));

    always_comb begin
        logic zr;
        blank_nxt = '0;
        zr        = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zr = zr & (wrk_step[4*i +: 4] == 4'd0);
            blank_nxt[i] = (i != 0) && zr && !carry_step;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            blank    <= '0;
            sh_q     <= '0;
            wrk_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            if (state == SHIFT) begin
                sh_q    <= sh_step;
                wrk_q   <= wrk_step;
                carry_q <= carry_step;
                cnt_q   <= cnt_q - CNT_W'(1);
                if (last) begin
                    bcd      <= wrk_step;
                    overflow <= carry_step;
                    blank    <= blank_nxt;
                end
            end else if (start) begin
                sh_q    <= bin;
                wrk_q   <= '0;
                carry_q <= 1'b0;
                cnt_q   <= CNT_W'(BIN_W);
            end
        end
    end
endmodule
